deskew_align: RTL and testbench
===============================

Name: deskew_align

Overview:
- Output-side re-alignment buffer for the systolic QRD-RLS array.
- Upstream, the row inputs are deliberately skewed, so lane k enters the array k*STEP cycles after lane 0. The array's results therefore leave staggered in the same way.
- This block removes that stagger. It delays each lane by a compensating amount and presents one aligned N-lane word with a single valid.
- It also keeps a running count of aligned words and a sticky flag that reports lanes arriving out of alignment.

Parameters:
- N, 3, number of lanes (array dimension).
- DATA_LENGTH, 16, bits per lane.
- STEP, 1, skew in cycles between adjacent lanes. 0 is legal.
- COUNT_W, 16, width of word_count.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- din, input, N*DATA_LENGTH, lane k at bits [k*DATA_LENGTH +: DATA_LENGTH]. Lane k is skewed k*STEP cycles after lane 0.
- din_valid, input, N, bit k qualifies lane k of din.
- dout, output, N*DATA_LENGTH, aligned word, same lane packing as din.
- dout_valid, output, 1, high for one cycle per aligned word.
- word_count, output, COUNT_W, number of aligned words emitted, modulo 2^COUNT_W.
- align_err, output, 1, sticky misalignment flag.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - All delay stages (data and valid) clear to 0.
  - dout = 0, dout_valid = 0, word_count = 0, align_err = 0.
  - Any word in flight is discarded; nothing is emitted for it after reset releases.
- Per-lane delay:
  - Lane k, data and its valid bit together, passes through a shift register of depth D_k = (N-1-k)*STEP.
  - Lane N-1 has depth 0 and uses its input directly.
  - Stages shift every cycle; there is no stall input.
- Alignment point:
  - The delayed valids v_k are compared in the same cycle.
  - For a correctly skewed word, all v_k are high together, (N-1)*STEP cycles after lane 0 was sampled.
- Output register, one stage, updated every rising edge:
  - All v_k = 1: dout takes the delayed data, dout_valid = 1, word_count increments.
  - Otherwise: dout holds its previous value and dout_valid = 0.
- Latency: lane 0 sampled at edge t gives dout_valid = 1 after edge t + (N-1)*STEP + 1.
  - With STEP = 0 the block is a single register stage with latency 1.
- Throughput: one aligned word per cycle; back-to-back words need no gap.
- align_err:
  - Set on any cycle where the v_k are neither all 0 nor all 1.
  - Cleared only by rst.
  - The misaligned word produces no dout_valid and does not increment the count.
- word_count wraps from 2^COUNT_W-1 to 0 with no flag.
- Lane data without its valid bit is don't-care. It is carried through the delay stages, but dout never samples it unless all v_k are high.
- Delay stages have no reset dependency beyond rst; no other reset or flush input exists.

Test Plan:
1. Single word, N=3, STEP=1: lane0 = 0x0011 valid at edge 0, lane1 = 0x0022 at edge 1, lane2 = 0x0033 at edge 2 -> after edge 3, dout = 0x0033_0022_0011, dout_valid = 1 for exactly one cycle, word_count = 1, align_err = 0.
2. Continuous stream: 10 consecutive correctly skewed words with lane data = word index -> dout_valid high for 10 consecutive cycles starting 3 cycles after the first lane-0 sample, data in order, word_count = 10.
3. Misalignment: word 2's lane1 valid is asserted one cycle late -> align_err rises and stays 1, word 2 is never emitted, words 1 and 3 are emitted correctly, word_count = 2.
4. Mid-stream reset: assert rst while 2 words are in flight -> all outputs 0 immediately, before the next edge. After release, no stale dout_valid appears, and a fresh word is emitted with word_count = 1.
5. Counter wrap, COUNT_W=4: 17 aligned words -> word_count reads 15 after word 15, then 0, then 1 after word 17.
6. STEP=0: all three lane valids asserted together at edge 0 with 0xAAAA/0xBBBB/0xCCCC -> after edge 1, dout = 0xCCCC_BBBB_AAAA, dout_valid = 1.

Source files
------------

// File: rtl/deskew_align.sv
// rtl/deskew_align.sv - removes the per-lane output stagger of the systolic QRD-RLS array
// Each lane is delayed so all lanes line up, then one registered aligned word is emitted.
module deskew_align #(
    parameter int N           = 3,
    parameter int DATA_LENGTH = 16,
    parameter int STEP        = 1,
    parameter int COUNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N*DATA_LENGTH-1:0] din,
    input  logic [N-1:0]             din_valid,
    output logic [N*DATA_LENGTH-1:0] dout,
    output logic                     dout_valid,
    output logic [COUNT_W-1:0]       word_count,
    output logic                     align_err
);

    logic [N*DATA_LENGTH-1:0] dly_data;
    logic [N-1:0]             dly_valid;
    logic                     all_v;
    logic                     any_v;

    for (genvar k = 0; k < N; k++) begin : g_lane
        localparam int D = (N - 1 - k) * STEP;

        if (D == 0) begin : g_direct
            assign dly_data[k*DATA_LENGTH +: DATA_LENGTH] = din[k*DATA_LENGTH +: DATA_LENGTH];
            assign dly_valid[k]                           = din_valid[k];
        end else begin : g_shift
            logic [DATA_LENGTH-1:0] sr_data [D];
            logic [D-1:0]           sr_valid;

            // Data and valid shift together so a lane's qualifier never drifts from its payload.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < D; i++) begin
                        sr_data[i] <= '0;
                    end
                    sr_valid <= '0;
                end else begin
                    sr_data[0]  <= din[k*DATA_LENGTH +: DATA_LENGTH];
                    sr_valid[0] <= din_valid[k];
                    for (int i = 1; i < D; i++) begin
                        sr_data[i]  <= sr_data[i-1];
                        sr_valid[i] <= sr_valid[i-1];
                    end
                end
            end

            assign dly_data[k*DATA_LENGTH +: DATA_LENGTH] = sr_data[D-1];
            assign dly_valid[k]                           = sr_valid[D-1];
        end
    end

    assign all_v = &dly_valid;
    assign any_v = |dly_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            word_count <= '0;
            align_err  <= 1'b0;
        end else begin
            dout_valid <= all_v;
            if (all_v) begin
                dout       <= dly_data;
                word_count <= word_count + COUNT_W'(1);
            end
            // A partial set of lanes means the upstream skew was broken; remember it until reset.
            if (any_v && !all_v) begin
                align_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_deskew_align.sv
// tb/tb_deskew_align.sv - self-checking bench for deskew_align (STEP=1, COUNT_W=4 and STEP=0 instances)
module tb_deskew_align;

    localparam int N    = 3;
    localparam int DL   = 16;
    localparam int W    = N * DL;
    localparam int STEP = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  din, din0;
    logic [N-1:0]  dv, dv0;

    logic [W-1:0]  dout, dout_w, dout_s;
    logic          dval, dval_w, dval_s;
    logic [15:0]   wc, wc_s;
    logic [3:0]    wc_w;
    logic          err, err_w, err_s;

    always #5 clk = ~clk;

    deskew_align #(.N(N), .DATA_LENGTH(DL), .STEP(STEP), .COUNT_W(16)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(dv),
        .dout(dout), .dout_valid(dval), .word_count(wc), .align_err(err));

    deskew_align #(.N(N), .DATA_LENGTH(DL), .STEP(STEP), .COUNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .din(din), .din_valid(dv),
        .dout(dout_w), .dout_valid(dval_w), .word_count(wc_w), .align_err(err_w));

    deskew_align #(.N(N), .DATA_LENGTH(DL), .STEP(0), .COUNT_W(16)) dut_s (
        .clk(clk), .rst(rst), .din(din0), .din_valid(dv0),
        .dout(dout_s), .dout_valid(dval_s), .word_count(wc_s), .align_err(err_s));

    int n_assert = 0;
    int n_fail   = 0;
    int c        = 0;
    int base     = 0;

    // Everything ever sampled, indexed by capture edge.
    logic [W-1:0] hdat [0:4095];
    logic [N-1:0] hv   [0:4095];

    logic [W-1:0] e_dout, e_dout_s;
    logic         e_val, e_err, e_val_s, e_err_s;
    int           e_cnt, e_cnt_s;

    logic [N-1:0] pv  [0:63];
    logic [N-1:0] pv0 [0:63];
    logic [W-1:0] pd  [0:63];
    logic [W-1:0] pd0 [0:63];

    function automatic logic [W-1:0] rnd_word();
        return W'({$urandom(), $urandom()});
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("dout_valid", 64'(dval), 64'(e_val));
        chk("dout", 64'(dout), 64'(e_dout));
        chk("word_count", 64'(wc), 64'(e_cnt[15:0]));
        chk("align_err", 64'(err), 64'(e_err));
        chk("w_dout", 64'(dout_w), 64'(e_dout));
        chk("w_word_count", 64'(wc_w), 64'(e_cnt[3:0]));
        chk("w_align_err", 64'(err_w), 64'(e_err));
        chk("s0_dout_valid", 64'(dval_s), 64'(e_val_s));
        chk("s0_dout", 64'(dout_s), 64'(e_dout_s));
        chk("s0_word_count", 64'(wc_s), 64'(e_cnt_s[15:0]));
        chk("s0_align_err", 64'(err_s), 64'(e_err_s));
    endtask

    task automatic clear_expect();
        e_dout = '0; e_val = 0; e_err = 0; e_cnt = 0;
        e_dout_s = '0; e_val_s = 0; e_err_s = 0; e_cnt_s = 0;
    endtask

    // One clock: drive, let the edge happen, apply the lane-alignment rule to the history, compare.
    task automatic cyc(input logic [N-1:0] v, input logic [W-1:0] d,
                       input logic [N-1:0] v0, input logic [W-1:0] d0);
        logic [W-1:0] w;
        logic         allv, anyv;
        int           idx;
        din = d; dv = v; din0 = d0; dv0 = v0;
        @(posedge clk);
        hdat[c] = d;
        if (rst) begin
            hv[c] = '0;
        end else begin
            hv[c] = v;
            allv = 1'b1; anyv = 1'b0; w = '0;
            for (int k = 0; k < N; k++) begin
                idx = c - (N - 1 - k) * STEP;
                if (idx >= base && hv[idx][k]) begin
                    anyv = 1'b1;
                    w[k*DL +: DL] = hdat[idx][k*DL +: DL];
                end else begin
                    allv = 1'b0;
                end
            end
            e_val = allv;
            if (allv) begin e_dout = w; e_cnt++; end
            if (anyv && !allv) e_err = 1'b1;
            e_val_s = &v0;
            if (&v0) begin e_dout_s = d0; e_cnt_s++; end
            if ((|v0) && !(&v0)) e_err_s = 1'b1;
        end
        c++;
        #1;
        chk_all();
    endtask

    task automatic clr();
        for (int t = 0; t < 64; t++) begin
            pv[t] = '0; pv0[t] = '0;
            pd[t] = rnd_word(); pd0[t] = rnd_word();
        end
    endtask

    task automatic add_word(input int t0, input int late_lane, input int late, input logic [W-1:0] d);
        int t;
        for (int k = 0; k < N; k++) begin
            t = t0 + k * STEP + ((k == late_lane) ? late : 0);
            pv[t][k] = 1'b1;
            pd[t][k*DL +: DL] = d[k*DL +: DL];
        end
    endtask

    task automatic run(input int n);
        for (int t = 0; t < n; t++) cyc(pv[t], pd[t], pv0[t], pd0[t]);
    endtask

    // Asserted between edges: outputs must already be zero before the next edge.
    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        clear_expect();
        base = c;
        chk_all();
        cyc(3'b111, rnd_word(), 3'b111, rnd_word());
        cyc(3'b111, rnd_word(), 3'b111, rnd_word());
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; din = '0; dv = '0; din0 = '0; dv0 = '0;
        clear_expect();
        #2;
        chk_all();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single skewed word on the STEP=1 pair, simultaneous word on the STEP=0 instance.
        clr();
        add_word(0, -1, 0, 48'h0033_0022_0011);
        pv0[0] = 3'b111;
        pd0[0] = 48'hCCCC_BBBB_AAAA;
        run(1);
        chk("t6_valid", 64'(dval_s), 64'd1);
        chk("t6_dout", 64'(dout_s), 64'h0000_CCCC_BBBB_AAAA);
        for (int t = 1; t < 3; t++) cyc(pv[t], pd[t], pv0[t], pd0[t]);
        chk("t1_valid", 64'(dval), 64'd1);
        chk("t1_dout", 64'(dout), 64'h0000_0033_0022_0011);
        for (int t = 3; t < 6; t++) cyc(pv[t], pd[t], pv0[t], pd0[t]);
        chk("t1_count", 64'(wc), 64'd1);
        chk("t1_err", 64'(err), 64'd0);

        // Ten back-to-back words, lane data = word index.
        clr();
        for (int i = 0; i < 10; i++) add_word(i, -1, 0, {3{16'(i)}});
        run(14);
        chk("t2_count", 64'(wc), 64'd11);

        // Middle word has lane 1 one cycle late.
        clr();
        add_word(0, -1, 0, rnd_word());
        add_word(4, 1, 1, rnd_word());
        add_word(8, -1, 0, rnd_word());
        run(14);
        chk("t3_err", 64'(err), 64'd1);
        chk("t3_count", 64'(wc), 64'd13);

        // Reset with two words in flight, then a fresh word.
        clr();
        add_word(0, -1, 0, rnd_word());
        add_word(1, -1, 0, rnd_word());
        run(2);
        pulse_reset();
        clr();
        add_word(0, -1, 0, rnd_word());
        run(6);
        chk("t4_count", 64'(wc), 64'd1);
        chk("t4_err", 64'(err), 64'd0);

        // Seventeen words through the 4-bit counter.
        pulse_reset();
        clr();
        for (int i = 0; i < 17; i++) add_word(i, -1, 0, rnd_word());
        run(20);
        chk("t5_wrap_count", 64'(wc_w), 64'd1);
        chk("t5_full_count", 64'(wc), 64'd17);

        // Randomized lane valids and data.
        pulse_reset();
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 2) == 0) ? N'($urandom()) : {N{($urandom_range(0, 1) == 1)}},
                rnd_word(),
                ($urandom_range(0, 3) == 0) ? N'($urandom()) : {N{($urandom_range(0, 1) == 1)}},
                rnd_word());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
